// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_multi
// Brief    : NUM_KEYS-channel push-button conditioner. Each channel has a
//            synchroniser, a reload-on-change debounce counter and
//            press/release/long-press pulses. KEY_LONG_PRESS_EN adds the
//            long-press counters; without it key_long stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_value,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic                key_event
);

    localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

`ifdef KEY_LONG_PRESS_EN
    localparam int                  C_LONG_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [C_LONG_W-1:0] C_LONG_MAX = C_LONG_W'(LONG_CYCLES);
    localparam logic [C_LONG_W-1:0] C_LONG_PRE = C_LONG_W'(LONG_CYCLES - 1);
    localparam logic [C_LONG_W-1:0] C_LONG_ONE = C_LONG_W'(1);
`endif

    logic [NUM_KEYS-1:0] w_n;
    logic [NUM_KEYS-1:0] w_value_d;
    logic [NUM_KEYS-1:0] w_press_d;
    logic [NUM_KEYS-1:0] w_release_d;
    logic [NUM_KEYS-1:0] w_long_d;
    logic                w_event_d;
    logic [NUM_KEYS-1:0] r_value_q;
    logic [NUM_KEYS-1:0] r_press_q;
    logic [NUM_KEYS-1:0] r_release_q;
    logic [NUM_KEYS-1:0] r_long_q;
    logic                r_event_q;

    assign w_n = key ^ {NUM_KEYS{ACTIVE_LOW}};

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic               r_s1_q;
            logic               r_s2_q;
            logic               r_s3_q;
            logic [C_CNT_W-1:0] r_cnt_q;
            logic [C_CNT_W-1:0] w_cnt_d;

            always_comb begin
                w_cnt_d = r_cnt_q;
                if (r_s2_q != r_s3_q) begin
                    w_cnt_d = C_CNT_LOAD;
                end else if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - C_CNT_ONE;
                end
            end

            // Commit takes the live s2, so a toggle landing on cnt==1 still commits.
            assign w_value_d[gi]   = (r_cnt_q == C_CNT_ONE) ? r_s2_q : r_value_q[gi];
            assign w_press_d[gi]   = w_value_d[gi] & ~r_value_q[gi];
            assign w_release_d[gi] = ~w_value_d[gi] & r_value_q[gi];

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    r_s1_q  <= 1'b0;
                    r_s2_q  <= 1'b0;
                    r_s3_q  <= 1'b0;
                    r_cnt_q <= '0;
                end else begin
                    r_s1_q  <= w_n[gi];
                    r_s2_q  <= r_s1_q;
                    r_s3_q  <= r_s2_q;
                    r_cnt_q <= w_cnt_d;
                end
            end

`ifdef KEY_LONG_PRESS_EN
            logic [C_LONG_W-1:0] r_hold_q;
            logic [C_LONG_W-1:0] w_hold_d;

            always_comb begin
                w_hold_d = r_hold_q;
                if (!r_value_q[gi]) begin
                    w_hold_d = '0;
                end else if (r_hold_q < C_LONG_MAX) begin
                    w_hold_d = r_hold_q + C_LONG_ONE;
                end
            end

            // Saturation at LONG_CYCLES makes this fire once per press.
            assign w_long_d[gi] = r_value_q[gi] && (r_hold_q == C_LONG_PRE);

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    r_hold_q <= '0;
                end else begin
                    r_hold_q <= w_hold_d;
                end
            end
`else
            // LONG_CYCLES has no effect in this build; the term is constant false.
            assign w_long_d[gi] = (LONG_CYCLES < 0);
`endif
        end
    endgenerate

    always_comb begin
        w_event_d = |{w_press_d, w_release_d, w_long_d};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_value_q   <= '0;
            r_press_q   <= '0;
            r_release_q <= '0;
            r_long_q    <= '0;
            r_event_q   <= 1'b0;
        end else begin
            r_value_q   <= w_value_d;
            r_press_q   <= w_press_d;
            r_release_q <= w_release_d;
            r_long_q    <= w_long_d;
            r_event_q   <= w_event_d;
        end
    end

    assign key_value   = r_value_q;
    assign key_press   = r_press_q;
    assign key_release = r_release_q;
    assign key_long    = r_long_q;
    assign key_event   = r_event_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_multi
// Brief    : Directed and random stimulus for key_debounce_multi, compared
//            each cycle against a sample-history model of the debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_multi;

    localparam int NK = 4;
    localparam int D  = 16;
    localparam int L  = 100;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [NK-1:0] key     = 4'hF;
    logic [NK-1:0] key_value;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;
    logic          key_event;

    key_debounce_multi #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .ACTIVE_LOW      (1'b1)
    ) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key         (key),
        .key_value   (key_value),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_event   (key_event)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // hist[k][j] = normalised pin level sampled j edges ago
    bit            hist [NK][D+4];
    int            held [NK];
    bit            kv   [NK];
    logic [NK-1:0] e_val, e_press, e_rel, e_long;
    logic          e_evt;

    always @(posedge sys_clk) begin : model
        bit old_v, new_v, commit;
        for (int k = 0; k < NK; k++) begin
            if (sys_rst) begin
                for (int j = 0; j < D + 4; j++) hist[k][j] = 1'b0;
                kv[k] = 1'b0; held[k] = 0;
                e_val[k] = 1'b0; e_press[k] = 1'b0; e_rel[k] = 1'b0; e_long[k] = 1'b0;
            end else begin
                for (int j = D + 3; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = ~key[k];
                // commit: a change entered the window D edges ago and nothing changed since
                commit = (hist[k][D+3] != hist[k][D+2]);
                for (int j = 3; j <= D + 1; j++)
                    if (hist[k][j] != hist[k][D+2]) commit = 1'b0;
                old_v   = kv[k];
                held[k] = old_v ? held[k] + 1 : 0;
                new_v   = commit ? hist[k][2] : old_v;
                kv[k]   = new_v;
                e_val[k]   = new_v;
                e_press[k] = new_v & ~old_v;
                e_rel[k]   = old_v & ~new_v;
`ifdef KEY_LONG_PRESS_EN
                e_long[k]  = (held[k] == L);
`else
                e_long[k]  = 1'b0;
`endif
            end
        end
        e_evt = |{e_press, e_rel, e_long};
    end

    always @(negedge sys_clk) begin
        if (check_en) begin
            n_vec++;
            if (key_value !== e_val) begin
                n_err++; $display("FAIL key_value @%0t: got %b expected %b", $time, key_value, e_val);
            end
            if (key_press !== e_press) begin
                n_err++; $display("FAIL key_press @%0t: got %b expected %b", $time, key_press, e_press);
            end
            if (key_release !== e_rel) begin
                n_err++; $display("FAIL key_release @%0t: got %b expected %b", $time, key_release, e_rel);
            end
            if (key_long !== e_long) begin
                n_err++; $display("FAIL key_long @%0t: got %b expected %b", $time, key_long, e_long);
            end
            if (key_event !== e_evt) begin
                n_err++; $display("FAIL key_event @%0t: got %b expected %b", $time, key_event, e_evt);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    function automatic bit pulse_of(input int sel, input int ch);
        case (sel)
            0:       return key_press[ch] === 1'b1;
            1:       return key_release[ch] === 1'b1;
            default: return key_long[ch] === 1'b1;
        endcase
    endfunction

    // cyc = number of edges after the call until the pulse is seen, -1 if never
    task automatic wait_pulse(input int sel, input int ch, input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            tick(1);
            if (pulse_of(sel, ch)) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

    initial begin
        int cyc;
        int cnt;
        int rate;

        key = 4'hF;
        sys_rst = 1'b1;
        tick(1);
        check_en = 1'b1;
        tick(2);
        chk("reset_value", int'(key_value), 0);
        chk("reset_press", int'(key_press), 0);
        chk("reset_release", int'(key_release), 0);
        chk("reset_long", int'(key_long), 0);
        chk("reset_event", int'(key_event), 0);
        sys_rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (|{key_press, key_release, key_long, key_event}) cnt++;
        end
        chk("reset_quiet", cnt, 0);

        key[0] = 1'b0;
        wait_pulse(0, 0, 40, cyc);
        chk("press0_latency", cyc, 19);
        chk("press0_value", int'(key_value[0]), 1);
        chk("press0_event", int'(key_event), 1);
        tick(1);
        chk("press0_single", int'(key_press[0]), 0);
        key[0] = 1'b1;
        wait_pulse(1, 0, 40, cyc);
        chk("release0_latency", cyc, 19);
        tick(5);

        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            key[1] = ~key[1];
            for (int j = 0; j < 5; j++) begin
                tick(1);
                if (key_press[1] | key_release[1]) cnt++;
            end
        end
        key[1] = 1'b0;
        chk("bounce_early_pulses", cnt, 0);
        wait_pulse(0, 1, 40, cyc);
        chk("bounce_press_latency", cyc, 19);
        key[1] = 1'b1;
        tick(30);

        key[2] = 1'b0;
        wait_pulse(0, 2, 40, cyc);
        chk("press2_latency", cyc, 19);
`ifdef KEY_LONG_PRESS_EN
        wait_pulse(2, 2, 150, cyc);
        chk("long2_latency", cyc, L);
`else
        tick(L);
`endif
        cnt = 0;
        for (int i = 0; i < 31; i++) begin
            tick(1);
            if (key_long[2]) cnt++;
        end
        chk("long2_once", cnt, 0);
        key[2] = 1'b1;
        wait_pulse(1, 2, 40, cyc);
        chk("release2_latency", cyc, 19);
        tick(5);

        key = 4'h0;
        wait_pulse(0, 0, 40, cyc);
        chk("simul_latency", cyc, 19);
        chk("simul_press", int'(key_press), 15);
        chk("simul_event", int'(key_event), 1);
        tick(1);
        chk("simul_event_single", int'(key_event), 0);
        key = 4'hF;
        wait_pulse(1, 0, 40, cyc);
        chk("simul_release", int'(key_release), 15);
        tick(5);

        key[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (|{key_press, key_release}) cnt++;
        end
        chk("midrst_no_pulse", cnt, 0);
        sys_rst = 1'b1;
        tick(2);
        chk("midrst_value", int'(key_value), 0);
        sys_rst = 1'b0;
        wait_pulse(0, 0, 40, cyc);
        chk("midrst_press", cyc, 19);

        for (int seg = 0; seg < 10; seg++) begin
            rate = $urandom_range(3, 160);
            for (int i = 0; i < 400; i++) begin
                for (int k = 0; k < NK; k++)
                    if ($urandom_range(0, rate - 1) == 0) key[k] = ~key[k];
                sys_rst = ($urandom_range(0, 1999) == 0);
                tick(1);
            end
        end
        sys_rst = 1'b0;
        key = 4'hF;
        tick(40);

        summary();
        $finish;
    end

endmodule
`default_nettype wire
